// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_NUM_REQ    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: first set request at or after the pointer, wrapping.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_c,
    output logic [IDX_W-1:0]   o_idx_c
);

    logic        w_found;
    int unsigned w_pos;

    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_pos = 32'(i_ptr) + off;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!w_found && i_req[IDX_W'(w_pos)]) begin
                w_found                  = 1'b1;
                o_gnt_c[IDX_W'(w_pos)]   = 1'b1;
                o_idx_c                  = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto one registered-read memory port, one access per 3 cycles.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             ack,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           mem_cs,
    output logic                           mem_rw,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_t              r_state;
    arb_state_t              w_next;
    logic                    w_latch;
    logic [IDX_W-1:0]        w_ptr;
    logic [IDX_W-1:0]        w_pick_idx;
    logic [NUM_REQ-1:0]      w_pick_gnt;
    logic [ADDR_WIDTH-1:0]   w_addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]      r_gnt;
    logic [NUM_REQ-1:0]      r_ack;
    logic                    r_rw;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_mem_cs;
    logic                    r_mem_rw;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req   (req),
        .i_ptr   (w_ptr),
        .o_gnt_c (w_pick_gnt),
        .o_idx_c (w_pick_idx)
    );

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_latch) begin
            r_ptr <= (32'(w_pick_idx) == NUM_REQ - 1) ? '0 : w_pick_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A winner still showing its ack is ineligible; the cycle then idles rather than passing down.
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|(w_pick_gnt & ~r_ack)) begin
                    w_next  = ST_ACCESS;
                    w_latch = 1'b1;
                end
            end
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rw        <= 1'b0;
            r_rdata     <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_ack       <= '0;
            r_mem_cs    <= w_latch;
            r_mem_rw    <= w_latch & req_rw[w_pick_idx];
            r_mem_addr  <= w_latch ? w_addr_arr[w_pick_idx]  : '0;
            r_mem_wdata <= w_latch ? w_wdata_arr[w_pick_idx] : '0;
            if (w_latch) begin
                r_gnt <= w_pick_gnt;
                r_rw  <= req_rw[w_pick_idx];
            end else if (r_state == ST_RESP) begin
                r_gnt <= '0;
                r_ack <= r_gnt;
                if (!r_rw) begin
                    r_rdata <= mem_rdata;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign mem_cs    = r_mem_cs;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read memory model.
module tb_mem_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned NR = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [NR-1:0]   req   = '0;
    logic [NR-1:0]   req_rw = '0;
    logic [AW-1:0]   a_arr [NR];
    logic [DW-1:0]   d_arr [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   ack;
    logic [DW-1:0]   rdata;
    logic            mem_cs;
    logic            mem_rw;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;

    logic [DW-1:0]   mem [256];
    logic            pl_en   = 1'b0;
    logic [AW-1:0]   pl_addr = '0;
    logic [DW-1:0]   pl_data = '0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign req_addr  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_wdata = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_cs) begin
            if (mem_rw) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .mem_cs    (mem_cs),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rw[i] = rw;
        a_arr[i]  = a;
        d_arr[i]  = d;
        req[i]    = 1'b1;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_ack(input int i, input string name);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ack[i]) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (ok !== 1'b1) $display("FAIL %s: ack[%0d] got 0 within 10 cycles, want 1", name, i);
        else passed++;
    endtask

    task automatic test_reset();
        req = 4'b0001;
        a_arr[0] = 8'h10;
        repeat (2) tick();
        total++; if (gnt !== 4'b0000)   $display("FAIL rst_gnt: got %b want 0000", gnt);       else passed++;
        total++; if (ack !== 4'b0000)   $display("FAIL rst_ack: got %b want 0000", ack);       else passed++;
        total++; if (rdata !== 8'h00)   $display("FAIL rst_rdata: got %h want 00", rdata);     else passed++;
        total++; if (mem_cs !== 1'b0)   $display("FAIL rst_cs: got %b want 0", mem_cs);        else passed++;
        total++; if (mem_addr !== 8'h0) $display("FAIL rst_addr: got %h want 00", mem_addr);   else passed++;
        req   = '0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        preload(8'h10, 8'hA5);
        set_req(0, 1'b0, 8'h10, 8'h00);
        tick();
        total++; if (mem_cs !== 1'b1)    $display("FAIL rd_cs: got %b want 1", mem_cs);         else passed++;
        total++; if (mem_rw !== 1'b0)    $display("FAIL rd_rw: got %b want 0", mem_rw);         else passed++;
        total++; if (mem_addr !== 8'h10) $display("FAIL rd_addr: got %h want 10", mem_addr);    else passed++;
        total++; if (gnt !== 4'b0001)    $display("FAIL rd_gnt: got %b want 0001", gnt);        else passed++;
        tick();
        total++; if (mem_cs !== 1'b0)    $display("FAIL rd_cs_one: got %b want 0", mem_cs);     else passed++;
        total++; if (ack !== 4'b0000)    $display("FAIL rd_ack_early: got %b want 0000", ack);  else passed++;
        tick();
        total++; if (ack !== 4'b0001)    $display("FAIL rd_ack: got %b want 0001", ack);        else passed++;
        total++; if (rdata !== 8'hA5)    $display("FAIL rd_data: got %h want a5", rdata);       else passed++;
        total++; if (gnt !== 4'b0000)    $display("FAIL rd_gnt_off: got %b want 0000", gnt);    else passed++;
        req[0] = 1'b0;
        tick();
        total++; if (ack !== 4'b0000)    $display("FAIL rd_ack_pulse: got %b want 0000", ack);  else passed++;
    endtask

    task automatic test_write_read();
        set_req(2, 1'b1, 8'h3F, 8'h5A);
        wait_ack(2, "wr_ack_wait");
        total++; if (ack !== 4'b0100)  $display("FAIL wr_ack: got %b want 0100", ack);        else passed++;
        total++; if (rdata !== 8'hA5)  $display("FAIL wr_rdata_hold: got %h want a5", rdata); else passed++;
        req[2] = 1'b0;
        tick();
        set_req(1, 1'b0, 8'h3F, 8'h00);
        wait_ack(1, "rb_ack_wait");
        total++; if (rdata !== 8'h5A)  $display("FAIL rb_data: got %h want 5a", rdata);       else passed++;
        req[1] = 1'b0;
        tick();
    endtask

`ifdef MEM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [NR-1:0] exp_g;
        reset_pulse();
        set_req(1, 1'b0, 8'h3F, 8'h00);
        set_req(3, 1'b0, 8'h10, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_g = ((k % 4) == 1 || (k % 4) == 2) ? 4'b0010 : 4'b0000;
            total++; if (gnt !== exp_g) $display("FAIL fp_gnt_k%0d: got %b want %b", k, gnt, exp_g); else passed++;
        end
        req = '0;
        repeat (3) tick();
    endtask
`else
    task automatic test_round_robin();
        logic [NR-1:0] exp_g;
        int            idx;
        reset_pulse();
        for (int i = 0; i < 4; i++) preload(8'(8'h40 + i), 8'(8'hC0 + i));
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h40 + i), 8'h00);
        for (int k = 1; k <= 15; k++) begin
            tick();
            idx   = ((k - 1) / 3) % 4;
            exp_g = '0;
            exp_g[idx] = 1'b1;
            if ((k % 3) == 1) begin
                total++; if (gnt !== exp_g) $display("FAIL rr_gnt_k%0d: got %b want %b", k, gnt, exp_g); else passed++;
            end else if ((k % 3) == 0) begin
                total++; if (ack !== exp_g) $display("FAIL rr_ack_k%0d: got %b want %b", k, ack, exp_g); else passed++;
                total++; if (rdata !== 8'(8'hC0 + idx)) $display("FAIL rr_data_k%0d: got %h want %h", k, rdata, 8'(8'hC0 + idx)); else passed++;
            end
        end
        req = '0;
        repeat (2) tick();
    endtask
`endif

    task automatic test_reset_mid();
        logic saw_ack;
        preload(8'h43, 8'hC3);
        set_req(0, 1'b0, 8'h10, 8'h00);
        tick();
        total++; if (mem_cs !== 1'b1)    $display("FAIL mid_cs_pre: got %b want 1", mem_cs);    else passed++;
        #1 reset = 1'b0;
        #1;
        total++; if (mem_cs !== 1'b0)    $display("FAIL mid_cs_async: got %b want 0", mem_cs);  else passed++;
        total++; if (gnt !== 4'b0000)    $display("FAIL mid_gnt_async: got %b want 0000", gnt); else passed++;
        req = '0;
        tick();
        reset   = 1'b1;
        saw_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack !== 4'b0000) saw_ack = 1'b1;
        end
        total++; if (saw_ack !== 1'b0)   $display("FAIL mid_no_ack: got %b want 0", saw_ack);   else passed++;
        set_req(3, 1'b0, 8'h43, 8'h00);
        tick();
        total++; if (mem_cs !== 1'b1)    $display("FAIL mid_idle_cs: got %b want 1", mem_cs);   else passed++;
        total++; if (mem_addr !== 8'h43) $display("FAIL mid_idle_addr: got %h want 43", mem_addr); else passed++;
        repeat (2) tick();
        total++; if (ack !== 4'b1000)    $display("FAIL mid_ack: got %b want 1000", ack);       else passed++;
        total++; if (rdata !== 8'hC3)    $display("FAIL mid_data: got %h want c3", rdata);      else passed++;
        req = '0;
        tick();
    endtask

    task automatic test_req_drop();
        preload(8'h20, 8'h3C);
        set_req(1, 1'b0, 8'h20, 8'h00);
        tick();
        total++; if (gnt !== 4'b0010)  $display("FAIL drop_gnt: got %b want 0010", gnt); else passed++;
        req[1] = 1'b0;
        repeat (2) tick();
        total++; if (ack !== 4'b0010)  $display("FAIL drop_ack: got %b want 0010", ack); else passed++;
        total++; if (rdata !== 8'h3C)  $display("FAIL drop_data: got %h want 3c", rdata); else passed++;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = '0;
            d_arr[i] = '0;
        end
        test_reset();
        test_single_read();
        test_write_read();
`ifdef MEM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_reset_mid();
        test_req_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 time units, want finished");
        $fatal(1);
    end

endmodule
